instruction_fetch: RTL and testbench

Fetch stage of the core. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. Each returned instruction is held in an instruction register and offered to decode (`controlUnit`) on a valid/ready handshake, with `opcode` broken out as bits [31:26]. It also handles branch redirects and halt requests coming back from decode/execute.

---
 rtl/instruction_fetch_pkg.sv | 27 ++
 rtl/fetch_pc.sv | 35 +++
 rtl/instruction_fetch.sv | 214 +++++++++++++++++++++
 tb/tb_instruction_fetch.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the fetch stage and the decode logic that consumes it.
// Holds the fetch state encoding, the opcode field width, and the opcode
// constants decode uses. NOP and HALT are also used by bench checks.
// No ports (package).
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

   localparam int OPCODE_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD,
      HALTED
   } fetch_state_t;

   localparam logic [OPCODE_WIDTH-1:0] OP_ALU    = 6'b000000;
   localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = 6'b100011;
   localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = 6'b101011;
   localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 6'b000100;
   localparam logic [OPCODE_WIDTH-1:0] OP_JUMP   = 6'b000010;
   localparam logic [OPCODE_WIDTH-1:0] OP_NOP    = 6'b011001;
   localparam logic [OPCODE_WIDTH-1:0] OP_HALT   = 6'b011010;

endpackage

// File: rtl/fetch_pc.sv
// -----------------------------------------------------------------------------
// fetch_pc
// Program counter register. A load takes priority over an increment, and the
// increment wraps modulo 2^ADDR_WIDTH without any flag.
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset, loads RESET_PC
//   load    - load target into the PC
//   inc     - advance the PC by one word
//   target  - value to load
//   pc      - current program counter
// -----------------------------------------------------------------------------
module fetch_pc #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic                  inc,
   input  logic [ADDR_WIDTH-1:0] target,
   output logic [ADDR_WIDTH-1:0] pc
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= target;
      end else if (inc) begin
         pc <= pc + ADDR_WIDTH'(1);
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage of the core. It owns the PC and reads instruction words over a
// req/ack handshake. It holds each returned word in an instruction register
// and offers it to decode on a valid/ready handshake. It also applies branch
// redirects and halt requests.
// Optional feature macro: FETCH_PERF_CNT_EN adds the fetch_count port and
// the accepted-instruction counter.
// Ports:
//   clock, reset_n           - clock, asynchronous active-low reset
//   imem_req/imem_addr       - registered read request and word address
//   imem_ack/imem_rdata      - one-cycle response pulse and data
//   instr_valid/instr_ready  - decode handshake
//   instr/opcode/instr_pc    - held instruction, its opcode field, its address
//   branch_taken/target      - redirect pulse and address
//   halt/halted              - halt pulse, sticky halted status
//   fetch_count              - accepted instructions (FETCH_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                    clock,
   input  logic                    reset_n,
   output logic                    imem_req,
   output logic [ADDR_WIDTH-1:0]   imem_addr,
   input  logic                    imem_ack,
   input  logic [INSTR_WIDTH-1:0]  imem_rdata,
   output logic                    instr_valid,
   input  logic                    instr_ready,
   output logic [INSTR_WIDTH-1:0]  instr,
   output logic [OPCODE_WIDTH-1:0] opcode,
   output logic [ADDR_WIDTH-1:0]   instr_pc,
   input  logic                    branch_taken,
   input  logic [ADDR_WIDTH-1:0]   branch_target,
   input  logic                    halt,
   output logic                    halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]             fetch_count
`endif
);

   fetch_state_t state, state_next;

   logic [ADDR_WIDTH-1:0]  pc;
   logic                   pc_load;
   logic                   pc_inc;
   logic                   drop, drop_next;
   logic                   halt_pend, halt_pend_next;
   logic                   req_next;
   logic [ADDR_WIDTH-1:0]  addr_next;
   logic                   valid_next;
   logic [INSTR_WIDTH-1:0] instr_next;
   logic [ADDR_WIDTH-1:0]  ipc_next;
   logic                   accept;

   fetch_pc #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_fetch_pc (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (pc_load),
      .inc     (pc_inc),
      .target  (branch_target),
      .pc      (pc)
   );

   // State and registered outputs. imem_req and imem_addr come straight from
   // flops, so no input has a combinational path to the memory side.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= RESET_PC;
         drop        <= 1'b0;
         halt_pend   <= 1'b0;
      end else begin
         state       <= state_next;
         imem_req    <= req_next;
         imem_addr   <= addr_next;
         instr_valid <= valid_next;
         instr       <= instr_next;
         instr_pc    <= ipc_next;
         drop        <= drop_next;
         halt_pend   <= halt_pend_next;
      end
   end

   // Next-state and handshake logic. Priority is halt, then branch, then
   // ready. In REQ the first cycle has imem_req low. A redirect or halt there
   // needs no drop, because nothing is in flight yet. Once the request is out,
   // it is always allowed to complete, and unwanted data is discarded.
   always_comb begin
      state_next     = state;
      req_next       = imem_req;
      addr_next      = imem_addr;
      valid_next     = instr_valid;
      instr_next     = instr;
      ipc_next       = instr_pc;
      drop_next      = drop;
      halt_pend_next = halt_pend;
      pc_load        = 1'b0;
      pc_inc         = 1'b0;
      accept         = 1'b0;

      case (state)
         IDLE: begin
            if (halt) begin
               state_next = HALTED;
            end else begin
               pc_load    = branch_taken;
               state_next = REQ;
            end
         end

         REQ: begin
            if (!imem_req) begin
               if (halt) begin
                  state_next = HALTED;
               end else if (branch_taken) begin
                  pc_load = 1'b1;
               end else begin
                  req_next  = 1'b1;
                  addr_next = pc;
               end
            end else if (imem_ack) begin
               req_next = 1'b0;
               if (halt || halt_pend) begin
                  drop_next      = 1'b0;
                  halt_pend_next = 1'b0;
                  state_next     = HALTED;
               end else if (branch_taken) begin
                  pc_load   = 1'b1;
                  drop_next = 1'b0;
               end else if (drop) begin
                  drop_next = 1'b0;
               end else begin
                  instr_next = imem_rdata;
                  ipc_next   = pc;
                  pc_inc     = 1'b1;
                  valid_next = 1'b1;
                  state_next = HOLD;
               end
            end else begin
               if (halt) begin
                  halt_pend_next = 1'b1;
                  drop_next      = 1'b1;
               end else if (branch_taken && !halt_pend) begin
                  pc_load   = 1'b1;
                  drop_next = 1'b1;
               end
            end
         end

         HOLD: begin
            if (halt) begin
               valid_next = 1'b0;
               state_next = HALTED;
            end else if (branch_taken) begin
               pc_load    = 1'b1;
               valid_next = 1'b0;
               state_next = REQ;
            end else if (instr_ready) begin
               accept     = 1'b1;
               valid_next = 1'b0;
               state_next = REQ;
            end
         end

         HALTED: begin
            req_next   = 1'b0;
            valid_next = 1'b0;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign opcode = instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
   assign halted = (state == HALTED);

`ifdef FETCH_PERF_CNT_EN
   // Counts only handshakes that complete. A branch or halt in the same cycle
   // kills the instruction, so that handshake is not counted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fetch_count <= 32'd0;
      end else if (accept) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

`ifndef SYNTHESIS
   // The memory must only respond to an outstanding request.
   ack_only_when_req : assert property (
      @(posedge clock) disable iff (!reset_n) imem_ack |-> imem_req
   );
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch with RESET_PC=0x0010.
// A small memory model answers each request after mem_latency cycles. The
// returned word is {addr[5:0]^6'h1B, 10'b0, addr^16'h0010}, so address 0x0010
// returns 0x2C000000.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [15:0] instr_pc;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_target = '0;
   logic        halt = 1'b0;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
`endif

   int total = 0;
   int bad = 0;
   int mem_latency = 1;
   int req_age = 0;

   instruction_fetch #(
      .ADDR_WIDTH  (16),
      .INSTR_WIDTH (32),
      .RESET_PC    (16'h0010)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .opcode        (opcode),
      .instr_pc      (instr_pc),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halt          (halt),
      .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count   (fetch_count)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {a[5:0] ^ 6'h1B, 10'b0, a ^ 16'h0010};
   endfunction

   // Memory model: ack in the mem_latency-th cycle that the request is seen high.
   always @(negedge clock) begin
      if (imem_req) req_age = req_age + 1;
      else          req_age = 0;
      if (imem_req && req_age == mem_latency) begin
         imem_ack   = 1'b1;
         imem_rdata = mem_word(imem_addr);
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = '0;
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic apply_stimulus(input logic br, input logic [15:0] tgt,
                                 input logic hl, input logic rdy);
      branch_taken  = br;
      branch_target = tgt;
      halt          = hl;
      instr_ready   = rdy;
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic check_count(input string name, input logic [31:0] expected);
`ifdef FETCH_PERF_CNT_EN
      check_output(name, fetch_count, expected);
`else
      if (expected === 32'hFFFF_FFFF) $display("[TB] unreachable count %s", name);
`endif
   endtask

   task automatic check_reset_values();
      check_output("rst_req",    {31'b0, imem_req},    32'd0);
      check_output("rst_addr",   {16'b0, imem_addr},   32'h0010);
      check_output("rst_instr",  instr,                32'd0);
      check_output("rst_opcode", {26'b0, opcode},      32'd0);
      check_output("rst_ipc",    {16'b0, instr_pc},    32'h0010);
      check_output("rst_valid",  {31'b0, instr_valid}, 32'd0);
      check_output("rst_halted", {31'b0, halted},      32'd0);
      check_count("rst_count", 32'd0);
   endtask

   typedef struct {
      logic        ready;
      logic        exp_req;
      logic [15:0] exp_addr;
      logic        exp_valid;
      logic [15:0] exp_ipc;
   } vec_t;

   vec_t vecs[14];

   initial begin
      logic [31:0] w;

      // First fetch, 5 cycles of back-pressure, then two more fetches.
      vecs[0]  = '{1'b0, 1'b0, 16'h0010, 1'b0, 16'h0000};
      vecs[1]  = '{1'b0, 1'b0, 16'h0010, 1'b0, 16'h0000};
      vecs[2]  = '{1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000};
      vecs[3]  = '{1'b0, 1'b0, 16'h0010, 1'b1, 16'h0010};
      vecs[4]  = '{1'b0, 1'b0, 16'h0010, 1'b1, 16'h0010};
      vecs[5]  = '{1'b0, 1'b0, 16'h0010, 1'b1, 16'h0010};
      vecs[6]  = '{1'b0, 1'b0, 16'h0010, 1'b1, 16'h0010};
      vecs[7]  = '{1'b0, 1'b0, 16'h0010, 1'b1, 16'h0010};
      vecs[8]  = '{1'b1, 1'b0, 16'h0010, 1'b1, 16'h0010};
      vecs[9]  = '{1'b0, 1'b0, 16'h0010, 1'b0, 16'h0000};
      vecs[10] = '{1'b0, 1'b1, 16'h0011, 1'b0, 16'h0000};
      vecs[11] = '{1'b1, 1'b0, 16'h0011, 1'b1, 16'h0011};
      vecs[12] = '{1'b0, 1'b0, 16'h0011, 1'b0, 16'h0000};
      vecs[13] = '{1'b0, 1'b1, 16'h0012, 1'b0, 16'h0000};

      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      repeat (3) tick();
      check_reset_values();
      reset_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         check_output($sformatf("v%0d_req", i),   {31'b0, imem_req},    {31'b0, vecs[i].exp_req});
         check_output($sformatf("v%0d_addr", i),  {16'b0, imem_addr},   {16'b0, vecs[i].exp_addr});
         check_output($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) begin
            w = mem_word(vecs[i].exp_ipc);
            check_output($sformatf("v%0d_ipc", i),    {16'b0, instr_pc}, {16'b0, vecs[i].exp_ipc});
            check_output($sformatf("v%0d_instr", i),  instr,             w);
            check_output($sformatf("v%0d_opcode", i), {26'b0, opcode},   {26'b0, w[31:26]});
         end
         if (i == 3) begin
            check_output("first_instr",  instr,           32'h2C00_0000);
            check_output("first_opcode", {26'b0, opcode}, 32'b001011);
         end
         apply_stimulus(1'b0, 16'h0000, 1'b0, vecs[i].ready);
         tick();
      end

      // Branch and ready together in HOLD: the branch wins, so nothing is counted.
      check_output("hold12_valid", {31'b0, instr_valid}, 32'd1);
      check_output("hold12_ipc",   {16'b0, instr_pc},    32'h0012);
      check_count("count_before_br", 32'd2);
      apply_stimulus(1'b1, 16'h0200, 1'b0, 1'b1);
      tick();
      check_output("brhold_valid", {31'b0, instr_valid}, 32'd0);
      check_output("brhold_req",   {31'b0, imem_req},    32'd0);
      check_count("brhold_count", 32'd2);
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      check_output("brhold_req2",  {31'b0, imem_req},  32'd1);
      check_output("brhold_addr2", {16'b0, imem_addr}, 32'h0200);
      tick();
      check_output("h200_ipc", {16'b0, instr_pc}, 32'h0200);
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1);
      mem_latency = 3;
      tick();

      // Branch while a latency-3 request is outstanding: that response is dropped.
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      check_count("count_3", 32'd3);
      tick();
      check_output("brreq_req",  {31'b0, imem_req},  32'd1);
      check_output("brreq_addr", {16'b0, imem_addr}, 32'h0201);
      tick();
      apply_stimulus(1'b1, 16'h0100, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      check_output("brreq_addr_stable", {16'b0, imem_addr}, 32'h0201);
      check_output("brreq_valid0",      {31'b0, instr_valid}, 32'd0);
      tick();
      check_output("brreq_drop_req",   {31'b0, imem_req},    32'd0);
      check_output("brreq_drop_valid", {31'b0, instr_valid}, 32'd0);
      tick();
      check_output("brreq_new_req",  {31'b0, imem_req},  32'd1);
      check_output("brreq_new_addr", {16'b0, imem_addr}, 32'h0100);
      repeat (3) tick();
      check_output("h100_valid", {31'b0, instr_valid}, 32'd1);
      check_output("h100_ipc",   {16'b0, instr_pc},    32'h0100);
      check_output("h100_instr", instr,                mem_word(16'h0100));

      // PC wrap: fetch 0xFFFF, accept it, then the next request goes to 0x0000.
      mem_latency = 1;
      apply_stimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      check_output("wrap_addr_ffff", {16'b0, imem_addr}, 32'h0000_FFFF);
      tick();
      check_output("wrap_ipc",    {16'b0, instr_pc}, 32'h0000_FFFF);
      check_output("wrap_opcode", {26'b0, opcode},   32'h24);
      check_count("wrap_count_pre", 32'd3);
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1);
      tick();
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      check_count("wrap_count_post", 32'd4);
      tick();
      check_output("wrap_req",  {31'b0, imem_req},  32'd1);
      check_output("wrap_addr", {16'b0, imem_addr}, 32'h0000);
      tick();
      check_output("h0_ipc", {16'b0, instr_pc}, 32'h0000);

      // Halt in HOLD beats ready. After that, branches are ignored and no request is made.
      apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1);
      tick();
      check_output("halt_halted", {31'b0, halted},      32'd1);
      check_output("halt_valid",  {31'b0, instr_valid}, 32'd0);
      check_count("halt_count", 32'd4);
      apply_stimulus(1'b1, 16'h0300, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 5; k++) begin
         check_output($sformatf("halted_req_%0d", k),  {31'b0, imem_req}, 32'd0);
         check_output($sformatf("halted_stay_%0d", k), {31'b0, halted},   32'd1);
         apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
         tick();
      end

      // Reset clears everything, then a halt during an outstanding request.
      reset_n = 1'b0;
      mem_latency = 3;
      #1;
      check_reset_values();
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      check_output("hreq_req",  {31'b0, imem_req},  32'd1);
      check_output("hreq_addr", {16'b0, imem_addr}, 32'h0010);
      apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      tick();
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      check_output("hreq_held_req", {31'b0, imem_req}, 32'd1);
      check_output("hreq_not_yet",  {31'b0, halted},   32'd0);
      tick();
      tick();
      check_output("hreq_halted", {31'b0, halted},      32'd1);
      check_output("hreq_req0",   {31'b0, imem_req},    32'd0);
      check_output("hreq_valid0", {31'b0, instr_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
